// File: rtl/countdown_arbiter_pkg.sv
// rtl/countdown_arbiter_pkg.sv - shared types and defaults for the countdown timer arbiter
//   Contents: arbiter FSM state enum and the default requester count / duration width.
package countdown_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LAUNCH  = 2'd1,
        WAIT    = 2'd2,
        RELEASE = 2'd3
    } state_e;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_TIME_W  = 16;

endpackage

// File: rtl/countdown_arbiter_if.sv
// rtl/countdown_arbiter_if.sv - requester and timer handshake bundle for countdown_arbiter
//   req/req_time : requester levels and packed durations (slice i = [i*TIME_W +: TIME_W])
//   grant/done   : one-hot owner and one-hot completion pulse
//   busy/active_id : timer ownership flag and current/last owner index
//   cd_start/cd_time_in/cd_stop : timer start pulse, duration, stop pulse
//   slave modport is the arbiter side; master modport is the requester/timer side.
interface countdown_arbiter_if
    import countdown_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int TIME_W  = DEF_TIME_W
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*TIME_W-1:0] req_time;
    logic [NUM_REQ-1:0]        grant;
    logic [NUM_REQ-1:0]        done;
    logic                      busy;
    logic [ID_W-1:0]           active_id;
    logic                      cd_start;
    logic [TIME_W-1:0]         cd_time_in;
    logic                      cd_stop;

    modport slave (
        input  req, req_time, cd_stop,
        output grant, done, busy, active_id, cd_start, cd_time_in
    );

    modport master (
        output req, req_time, cd_stop,
        input  grant, done, busy, active_id, cd_start, cd_time_in
    );

endinterface

// File: rtl/countdown_arbiter_rr_arbiter.sv
// rtl/countdown_arbiter_rr_arbiter.sv - combinational round-robin pick
//   req    : pending request vector
//   ptr    : index of the last served requester
//   winner : first set req bit scanning upward from ptr+1, wrapping
//   valid  : any request pending
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] winner,
    output logic            valid
);

    int              idx_i;
    logic [ID_W-1:0] idx;

    // Offsets 1..N visit ptr+1 first and ptr itself last, so a requester
    // that was just served only wins again when nobody else is waiting.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx_i  = 0;
        idx    = '0;
        for (int k = 1; k <= N; k++) begin
            idx_i = int'(ptr) + k;
            if (idx_i >= N) begin
                idx_i = idx_i - N;
            end
            idx = ID_W'(idx_i);
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/countdown_arbiter.sv
// rtl/countdown_arbiter.sv - shares one countdown timer between NUM_REQ requesters
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : countdown_arbiter_if.slave (requests in, grant/done/busy/active_id out,
//         cd_start/cd_time_in to the timer, cd_stop from the timer)
//   All outputs are registered.
module countdown_arbiter
    import countdown_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int TIME_W  = DEF_TIME_W
) (
    input  logic                 clk,
    input  logic                 rst,
    countdown_arbiter_if.slave   bus
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam logic [ID_W-1:0] PTR_RESET = ID_W'(NUM_REQ - 1);

    state_e              state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic                busy_q, busy_d;
    logic [ID_W-1:0]     active_id_q, active_id_d;
    logic                cd_start_q, cd_start_d;
    logic [TIME_W-1:0]   cd_time_in_q, cd_time_in_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;

    logic [ID_W-1:0]     pick_id;
    logic                pick_valid;
    logic [TIME_W-1:0]   slice [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign slice[i] = bus.req_time[i*TIME_W +: TIME_W];
    end

    rr_arbiter #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_rr (
        .req    (bus.req),
        .ptr    (ptr_q),
        .winner (pick_id),
        .valid  (pick_valid)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        done_d       = done_q;
        busy_d       = busy_q;
        active_id_d  = active_id_q;
        cd_start_d   = cd_start_q;
        cd_time_in_d = cd_time_in_q;
        ptr_d        = ptr_q;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d          = '0;
                    grant_d[pick_id] = 1'b1;
                    active_id_d      = pick_id;
                    // Duration is sampled once here; later req_time changes
                    // cannot disturb a running countdown.
                    cd_time_in_d     = slice[pick_id];
                    cd_start_d       = 1'b1;
                    busy_d           = 1'b1;
                    state_d          = LAUNCH;
                end
            end
            LAUNCH: begin
                cd_start_d = 1'b0;
                state_d    = WAIT;
            end
            WAIT: begin
                // The timer has no abort, so only cd_stop ends a run even if
                // the owner has already dropped its request.
                if (bus.cd_stop) begin
                    grant_d             = '0;
                    busy_d              = 1'b0;
                    done_d              = '0;
                    done_d[active_id_q] = 1'b1;
                    ptr_d               = active_id_q;
                    state_d             = RELEASE;
                end
            end
            RELEASE: begin
                done_d  = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            done_q       <= '0;
            busy_q       <= 1'b0;
            active_id_q  <= '0;
            cd_start_q   <= 1'b0;
            cd_time_in_q <= '0;
            ptr_q        <= PTR_RESET;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            active_id_q  <= active_id_d;
            cd_start_q   <= cd_start_d;
            cd_time_in_q <= cd_time_in_d;
            ptr_q        <= ptr_d;
        end
    end

    assign bus.grant      = grant_q;
    assign bus.done       = done_q;
    assign bus.busy       = busy_q;
    assign bus.active_id  = active_id_q;
    assign bus.cd_start   = cd_start_q;
    assign bus.cd_time_in = cd_time_in_q;

endmodule

// File: tb/tb_countdown_arbiter.sv
// tb/tb_countdown_arbiter.sv - scoreboard bench for countdown_arbiter with a countdown timer model
module tb_countdown_arbiter;

    localparam int NUM_REQ = 4;
    localparam int TIME_W  = 16;

    typedef struct {
        int id;
        int t;
    } exp_t;

    logic clk;
    logic rst;
    logic man_stop;
    logic tmr_stop;
    logic tmr_run;
    logic [TIME_W-1:0] tmr_cnt;

    int checks;
    int errors;

    exp_t start_q[$];
    int   done_q[$];
    exp_t e;
    logic [NUM_REQ-1:0] prev_done;

    countdown_arbiter_if #(.NUM_REQ(NUM_REQ), .TIME_W(TIME_W)) bus ();

    countdown_arbiter #(.NUM_REQ(NUM_REQ), .TIME_W(TIME_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.cd_stop = tmr_stop | man_stop;

    // Timer model: loads on cd_start, counts down once per cycle, pulses stop at zero.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr_run  <= 1'b0;
            tmr_cnt  <= '0;
            tmr_stop <= 1'b0;
        end else begin
            tmr_stop <= 1'b0;
            if (bus.cd_start) begin
                tmr_run <= 1'b1;
                tmr_cnt <= bus.cd_time_in;
            end else if (tmr_run) begin
                if (tmr_cnt == 0) begin
                    tmr_stop <= 1'b1;
                    tmr_run  <= 1'b0;
                end else begin
                    tmr_cnt <= tmr_cnt - 1'b1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_run(input int id, input int t);
        exp_t x;
        x.id = id;
        x.t  = t;
        start_q.push_back(x);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.done == '0 && n < 100);
        if (bus.done == '0) check({tag, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic wait_start(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.cd_start && n < 100);
        if (!bus.cd_start) check({tag, "_timeout"}, 32'd1, 32'd0);
    endtask

    // Scoreboard monitor: every launch pops the expected owner/duration,
    // every done pulse pops the owner recorded at its launch.
    always @(negedge clk) begin
        if (bus.cd_start) begin
            if (start_q.size() == 0) begin
                check("start_unexpected", 32'd1, 32'd0);
            end else begin
                e = start_q.pop_front();
                check("start_id", 32'(bus.active_id), e.id);
                check("start_time", 32'(bus.cd_time_in), e.t);
                check("start_grant", 32'(bus.grant), 32'd1 << e.id);
                done_q.push_back(e.id);
            end
        end
        if (bus.busy) check("grant_onehot", $countones(bus.grant), 32'd1);
        if (bus.done != '0) begin
            check("done_one_cycle", 32'(prev_done), 32'd0);
            if (done_q.size() == 0) check("done_unexpected", 32'(bus.done), 32'd0);
            else check("done_id", 32'(bus.done), 32'd1 << done_q.pop_front());
        end
        prev_done = bus.done;
    end

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        checks    = 0;
        errors    = 0;
        prev_done = '0;
        man_stop  = 1'b0;
        bus.req      = '0;
        bus.req_time = '0;
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        step(1);

        // Reset state
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_cd_start", 32'(bus.cd_start), 32'd0);
        check("rst_cd_time_in", 32'(bus.cd_time_in), 32'd0);
        check("rst_active_id", 32'(bus.active_id), 32'd0);

        // 1: single requester, latency of one cycle
        bus.req_time[0*TIME_W +: TIME_W] = 16'd3;
        bus.req = 4'b0001;
        push_run(0, 3);
        step(1);
        check("t1_latency", 32'(bus.cd_start), 32'd1);
        step(1);
        check("t1_start_pulse", 32'(bus.cd_start), 32'd0);
        check("t1_busy", 32'(bus.busy), 32'd1);
        wait_done("t1");
        bus.req = '0;
        step(1);
        check("t1_done_clear", 32'(bus.done), 32'd0);
        check("t1_busy_clear", 32'(bus.busy), 32'd0);

        // 2: all four requesting from reset pointer -> 0,1,2,3,0
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        bus.req_time = {16'd4, 16'd3, 16'd2, 16'd1};
        bus.req = 4'b1111;
        push_run(0, 1);
        push_run(1, 2);
        push_run(2, 3);
        push_run(3, 4);
        push_run(0, 1);
        for (int i = 0; i < 5; i++) wait_done("t2");
        bus.req = '0;
        step(3);
        check("t2_queue_empty", start_q.size(), 32'd0);

        // 3: owner drops req and its duration changes during WAIT
        bus.req_time[2*TIME_W +: TIME_W] = 16'd7;
        bus.req = 4'b0100;
        push_run(2, 7);
        wait_start("t3");
        step(2);
        bus.req = '0;
        bus.req_time[2*TIME_W +: TIME_W] = 16'd99;
        step(2);
        check("t3_no_abort_busy", 32'(bus.busy), 32'd1);
        check("t3_no_abort_grant", 32'(bus.grant), 32'b0100);
        check("t3_time_held", 32'(bus.cd_time_in), 32'd7);
        wait_done("t3");
        step(2);

        // 4: spurious stop in IDLE, then in LAUNCH
        man_stop = 1'b1;
        step(1);
        man_stop = 1'b0;
        step(1);
        check("t4_idle_done", 32'(bus.done), 32'd0);
        check("t4_idle_busy", 32'(bus.busy), 32'd0);
        check("t4_idle_grant", 32'(bus.grant), 32'd0);
        bus.req_time[0*TIME_W +: TIME_W] = 16'd5;
        bus.req = 4'b0001;
        push_run(0, 5);
        step(1);
        check("t4_latency", 32'(bus.cd_start), 32'd1);
        man_stop = 1'b1;
        bus.req = '0;
        step(1);
        man_stop = 1'b0;
        check("t4_launch_busy", 32'(bus.busy), 32'd1);
        check("t4_launch_done", 32'(bus.done), 32'd0);
        check("t4_launch_grant", 32'(bus.grant), 32'b0001);
        step(1);
        check("t4_launch_hold", 32'(bus.busy), 32'd1);
        wait_done("t4");
        step(2);

        // 5: reset in the middle of WAIT
        bus.req_time[1*TIME_W +: TIME_W] = 16'd20;
        bus.req = 4'b0010;
        push_run(1, 20);
        wait_start("t5");
        step(3);
        rst = 1'b1;
        #1;
        check("t5_rst_grant", 32'(bus.grant), 32'd0);
        check("t5_rst_busy", 32'(bus.busy), 32'd0);
        check("t5_rst_done", 32'(bus.done), 32'd0);
        check("t5_rst_cd_start", 32'(bus.cd_start), 32'd0);
        done_q.delete();
        start_q.delete();
        bus.req = '0;
        step(2);
        rst = 1'b0;
        bus.req_time[2*TIME_W +: TIME_W] = 16'd2;
        bus.req = 4'b0100;
        push_run(2, 2);
        wait_done("t5");
        bus.req = '0;
        step(2);

        // 6: zero duration still completes through the timer stop
        bus.req_time[3*TIME_W +: TIME_W] = 16'd0;
        bus.req = 4'b1000;
        push_run(3, 0);
        wait_done("t6");
        bus.req = '0;
        step(6);
        check("t6_done_queue", done_q.size(), 32'd0);
        check("t6_idle_busy", 32'(bus.busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
